// File: rtl/stopwatch_pkg.sv
// Shared BCD types and helpers for the stopwatch counter chain.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Limit a preset digit to the largest value its modulus allows.
    function automatic bcd_t bcd_clamp(input bcd_t value, input bcd_t mod);
        bcd_t top;
        top = 4'(mod - 4'd1);
        return (value >= mod) ? top : value;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with its own modulus: clamped load, up/down step, optional wrap.
module bcd_digit_cell
    import stopwatch_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t load_digit,
    input  logic cnt_in,
    input  logic up_dn,
    input  logic wrap_en,
    output bcd_t digit,
    output logic is_zero,
    output logic is_max
);

    localparam bcd_t TOP = 4'(MOD - 1);

    if (MOD < 2 || MOD > 32'(BCD_MAX) + 1) begin : g_bad_mod
        $error("bcd_digit_cell: MOD must be within 2..10");
    end

    bcd_t digit_q, digit_d;
    logic is_zero_q, is_max_q;

    // wrap_en low means the chain is at its terminal value: an edge digit holds.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit, 4'(MOD));
        end else if (cnt_in) begin
            if (up_dn) begin
                if (digit_q == TOP) begin
                    if (wrap_en) digit_d = '0;
                end else begin
                    digit_d = 4'(digit_q + 4'd1);
                end
            end else begin
                if (digit_q == '0) begin
                    if (wrap_en) digit_d = TOP;
                end else begin
                    digit_d = 4'(digit_q - 4'd1);
                end
            end
        end
    end

    // Flags are registered from the next value so they line up with digit_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q   <= '0;
            is_zero_q <= 1'b1;
            is_max_q  <= (TOP == '0);
        end else begin
            digit_q   <= digit_d;
            is_zero_q <= (digit_d == '0);
            is_max_q  <= (digit_d == TOP);
        end
    end

    assign digit   = digit_q;
    assign is_zero = is_zero_q;
    assign is_max  = is_max_q;

endmodule

// File: rtl/bcd_chain_counter.sv
// Cascadable chain of per-digit-modulus BCD counters with wrap/saturate and rollover pulse.
module bcd_chain_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned               NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0]   DIGIT_MOD  = 16'h6A6A
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        tick,
    input  logic                        up_dn,
    input  logic                        wrap_en,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     load_val,
    output logic [4*NUM_DIGITS-1:0]     digits,
    output logic                        carry_out,
    output logic                        at_zero,
    output logic                        at_max
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_width
        $error("bcd_chain_counter: NUM_DIGITS must be within 1..8");
    end

    logic [NUM_DIGITS:0]   up_chain;
    logic [NUM_DIGITS:0]   dn_chain;
    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS-1:0] is_max;
    logic [NUM_DIGITS-1:0] step;
    logic                  cnt;
    logic                  terminal;
    logic                  cell_wrap;
    logic                  carry_q, carry_d;

    assign cnt         = en & tick & ~load;
    assign up_chain[0] = 1'b1;
    assign dn_chain[0] = 1'b1;

    // Digit i steps when every lower digit sits at its rollover edge.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign up_chain[i+1] = up_chain[i] & is_max[i];
        assign dn_chain[i+1] = dn_chain[i] & is_zero[i];
        assign step[i]       = cnt & (up_dn ? up_chain[i] : dn_chain[i]);

        bcd_digit_cell #(
            .MOD (32'(DIGIT_MOD[4*i +: 4]))
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .cnt_in     (step[i]),
            .up_dn      (up_dn),
            .wrap_en    (cell_wrap),
            .digit      (digits[4*i +: 4]),
            .is_zero    (is_zero[i]),
            .is_max     (is_max[i])
        );
    end

    assign terminal  = up_dn ? up_chain[NUM_DIGITS] : dn_chain[NUM_DIGITS];
    assign cell_wrap = wrap_en | ~terminal;

    always_comb begin
        carry_d = cnt & terminal & wrap_en;
    end

    always_ff @(posedge clk) begin
        if (reset) carry_q <= 1'b0;
        else       carry_q <= carry_d;
    end

    assign carry_out = carry_q;
    assign at_zero   = dn_chain[NUM_DIGITS];
    assign at_max    = up_chain[NUM_DIGITS];

endmodule
